// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width, iteration counter width, MUL FSM states.
// Used by the shift-add multiplier and its datapath step.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add M to the upper half,
// then shift the 65-bit {carry, acc_hi, mlo} right by one.
module mul_step
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_mlo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_mlo
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_acc_hi}
               + (i_mlo[0] ? {1'b0, i_m} : '0);

  // carry lands in bit 63, the consumed multiplier bit falls off
  assign {o_acc_hi, o_mlo} = {w_sum, i_mlo[WIDTH-1:1]};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 32x32->64 shift-add multiplier with busy/done.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo
);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic               w_last;
  logic               w_exit;
  logic [2*WIDTH-1:0] w_shifted;

  mul_step u_step (
    .i_acc_hi (r_p[2*WIDTH-1:WIDTH]),
    .i_mlo    (r_p[WIDTH-1:0]),
    .i_m      (r_m),
    .o_acc_hi (w_step_hi),
    .o_mlo    (w_step_lo)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_EXIT_EN
  logic [CNT_W-1:0] w_sh;
  logic [WIDTH-1:0] w_mask;

  // low (WIDTH-count) bits of P are the multiplier bits not yet consumed
  assign w_sh      = CNT_W'(WIDTH) - r_cnt;
  assign w_mask    = ~({WIDTH{1'b1}} << w_sh);
  assign w_exit    = ((r_p[WIDTH-1:0] & w_mask) == '0);
  assign w_shifted = r_p >> w_sh;
`else
  assign w_exit    = 1'b0;
  assign w_shifted = r_p;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_exit || w_last) w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_m   <= a;
      r_p   <= {{WIDTH{1'b0}}, b};
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (w_exit) begin
        r_p   <= w_shifted;
        r_cnt <= CNT_W'(WIDTH);
      end else begin
        r_p   <= {w_step_hi, w_step_lo};
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign p_hi = r_p[2*WIDTH-1:WIDTH];
  assign p_lo = r_p[WIDTH-1:0];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed corner cases plus
// random operand pairs checked against a plain 64-bit product model.
module tb_shift_add_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] p_hi;
  logic [31:0] p_lo;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  shift_add_multiplier dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p_hi  (p_hi),
    .p_lo  (p_lo)
  );

  always #5 clock = ~clock;

  // edges since the most recent start edge
  always @(posedge clock) begin
    if (start) cyc = 0;
    else cyc++;
  end

  function automatic int exp_lat(input logic [31:0] v);
`ifdef MUL_EARLY_EXIT_EN
    int m;
    m = -1;
    for (int i = 0; i < 32; i++)
      if (v[i]) m = i;
    if (m < 0) return 1;
    return (m + 2 > 32) ? 32 : m + 2;
`else
    return 32;
`endif
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: compare on each rising edge of done
  always @(negedge clock) begin
    exp_t e;
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got p=%h expected no result",
                 {p_hi, p_lo});
      end else begin
        e = q.pop_front();
        n_vec++;
        if ({p_hi, p_lo} !== e.prod) begin
          n_err++;
          $display("FAIL product: got %h expected %h",
                   {p_hi, p_lo}, e.prod);
        end
        n_vec++;
        if (cyc != e.lat) begin
          n_err++;
          $display("FAIL latency: got %0d expected %0d", cyc, e.lat);
        end
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input bit push);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    if (push) begin
      e.prod = ref_mul(ia, ib);
      e.lat  = exp_lat(ib);
      q.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    chk("busy_after_start", {63'd0, busy}, {63'd0, exp_lat(ib) > 1});
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] pe;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_p", {p_hi, p_lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd7, 32'd6, 1'b1);
    wait_done();
    pe = ref_mul(32'd7, 32'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_done", {63'd0, done}, 64'd1);
      chk("hold_busy", {63'd0, busy}, 64'd0);
      chk("hold_p", {p_hi, p_lo}, pe);
    end

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    issue(32'h8000_0000, 32'd2, 1'b1);
    wait_done();
    issue(32'd0, 32'h1234_5678, 1'b1);
    wait_done();
    issue($urandom, 32'd0, 1'b1);
    wait_done();
    issue($urandom, 32'd1, 1'b1);
    wait_done();
    issue($urandom, 32'h8000_0000, 1'b1);
    wait_done();

    // restart while running: only the second operation completes
    issue(32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge clock);
    issue(32'd9, 32'd9, 1'b1);
    wait_done();

    // asynchronous reset between edges while running
    issue(32'd5, 32'hF0F0_F0F3, 1'b0);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_p", {p_hi, p_lo}, 64'd0);
    #1 reset = 1'b0;
    @(negedge clock);
    issue(32'd11, 32'd13, 1'b1);
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) rb = rb >> $urandom_range(0, 31);
      issue(ra, rb, 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clock);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
